// File: rtl/pc_sequencer.sv
// Fetch/issue/execute sequencer that owns the architectural PC and the imem handshake.
// Optional misaligned-target trap is enabled by defining PCSEQ_ALIGN_TRAP_EN.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] TRAP_VEC = 16'h0004
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready,
    input  logic        resolve_valid,
    input  logic        flag_branch,
    input  logic        aluZero,
    input  logic [15:0] branchOff,
    input  logic        flag_jump,
    input  logic [15:0] jumpAddr,
    input  logic        halt,
    output logic [15:0] pc,
    output logic        halted,
    output logic        trap,
    output logic [15:0] trap_pc
);

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        EXEC,
        HALTED
    } state_t;

    state_t      state;
    logic [15:0] seq_pc;
    logic [15:0] target_pc;

    // Jump outranks a taken branch; all additions wrap at 16 bits.
    always_comb begin
        seq_pc = pc + 16'd2;
        if (flag_jump) begin
            target_pc = jumpAddr;
        end else if (flag_branch && aluZero) begin
            target_pc = seq_pc + branchOff;
        end else begin
            target_pc = seq_pc;
        end
    end

    assign imem_addr = pc;

`ifndef PCSEQ_ALIGN_TRAP_EN
    assign trap    = 1'b0;
    assign trap_pc = '0;
`endif

    // imem_req is held low for the first FETCH cycle after reset, so an ack is
    // only honoured once the request is actually visible on the bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
`ifdef PCSEQ_ALIGN_TRAP_EN
            trap        <= 1'b0;
            trap_pc     <= '0;
`endif
        end else begin
`ifdef PCSEQ_ALIGN_TRAP_EN
            trap <= 1'b0;
`endif
            case (state)
                FETCH: begin
                    if (imem_req && imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (resolve_valid) begin
`ifdef PCSEQ_ALIGN_TRAP_EN
                        if (target_pc[0]) begin
                            pc      <= TRAP_VEC;
                            trap    <= 1'b1;
                            trap_pc <= target_pc;
                        end else begin
                            pc <= target_pc;
                        end
`else
                        pc <= target_pc & 16'hFFFE;
`endif
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                HALTED: begin
                    halted   <= 1'b1;
                    imem_req <= 1'b0;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected instr/pc values are queued when
// stimulus is driven and popped when the sequencer presents its result.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        resolve_valid;
    logic        flag_branch;
    logic        aluZero;
    logic [15:0] branchOff;
    logic        flag_jump;
    logic [15:0] jumpAddr;
    logic        halt;
    logic [15:0] pc;
    logic        halted;
    logic        trap;
    logic [15:0] trap_pc;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];
    logic [15:0] cur_pc;

    pc_sequencer #(
        .RESET_PC(16'h0000),
        .TRAP_VEC(16'h0004)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .resolve_valid(resolve_valid),
        .flag_branch  (flag_branch),
        .aluZero      (aluZero),
        .branchOff    (branchOff),
        .flag_jump    (flag_jump),
        .jumpAddr     (jumpAddr),
        .halt         (halt),
        .pc           (pc),
        .halted       (halted),
        .trap         (trap),
        .trap_pc      (trap_pc)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit reached, expected self-termination");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [15:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input logic [15:0] got);
        check_eq("sb_nonempty", 16'(exp_q.size() != 0), 16'd1);
        if (exp_q.size() != 0) check_eq(tag_q.pop_front(), got, exp_q.pop_front());
    endtask

    task automatic clear_ctrl();
        resolve_valid = 1'b0;
        flag_branch   = 1'b0;
        aluZero       = 1'b0;
        branchOff     = 16'h0000;
        flag_jump     = 1'b0;
        jumpAddr      = 16'h0000;
        halt          = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 50 && !imem_req; i++) tick();
        check_eq("req_rise", 16'(imem_req), 16'd1);
    endtask

    // One full instruction: fetch with ack delay, issue/exec stalls, then resolve.
    task automatic run_instr(input logic [15:0] rdata, input int unsigned ack_wait,
                             input int unsigned stall, input logic jump, input logic [15:0] jaddr,
                             input logic br, input logic zero, input logic [15:0] off,
                             input logic hlt, input logic [15:0] exp_pc,
                             input logic exp_trap, input logic [15:0] exp_trap_pc);
        wait_req();
        for (int unsigned i = 0; i < ack_wait; i++) begin
            check_eq("fetch_addr", imem_addr, cur_pc);
            check_eq("fetch_req_hold", 16'(imem_req), 16'd1);
            tick();
        end
        check_eq("fetch_addr", imem_addr, cur_pc);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        push_exp("instr", rdata);
        push_exp("instr_pc", cur_pc);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        for (int i = 0; i < 50 && !instr_valid; i++) tick();
        check_eq("instr_valid", 16'(instr_valid), 16'd1);
        pop_check(instr);
        pop_check(instr_pc);
        check_eq("req_drop", 16'(imem_req), 16'd0);
        for (int unsigned i = 0; i < stall; i++) begin
            tick();
            check_eq("issue_stall", 16'(instr_valid), 16'd1);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("valid_drop", 16'(instr_valid), 16'd0);
        flag_jump   = jump;
        jumpAddr    = jaddr;
        flag_branch = br;
        aluZero     = zero;
        branchOff   = off;
        halt        = hlt;
        for (int unsigned i = 0; i < stall; i++) begin
            tick();
            check_eq("exec_stall_pc", pc, cur_pc);
        end
        resolve_valid = 1'b1;
        push_exp("next_pc", exp_pc);
        tick();
        clear_ctrl();
        pop_check(pc);
        check_eq("halted", 16'(halted), 16'(hlt));
        check_eq("refetch_req", 16'(imem_req), 16'(!hlt));
        check_eq("trap", 16'(trap), 16'(exp_trap));
        check_eq("trap_pc", trap_pc, exp_trap_pc);
        if (exp_trap) begin
            tick();
            check_eq("trap_one_cycle", 16'(trap), 16'd0);
        end
        cur_pc = exp_pc;
    endtask

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0000;
        instr_ready = 1'b0;
        clear_ctrl();
        cur_pc = 16'h0000;
        tick();
        tick();
        check_eq("rst_pc", pc, 16'h0000);
        check_eq("rst_req", 16'(imem_req), 16'd0);
        check_eq("rst_valid", 16'(instr_valid), 16'd0);
        check_eq("rst_halted", 16'(halted), 16'd0);
        check_eq("rst_instr", instr, 16'h0000);
        check_eq("rst_instr_pc", instr_pc, 16'h0000);
        check_eq("rst_trap", 16'(trap), 16'd0);
        check_eq("rst_trap_pc", trap_pc, 16'h0000);
        reset = 1'b0;
        tick();
        check_eq("req_first_cycle", 16'(imem_req), 16'd1);

        run_instr(16'h1234, 2, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b0, 16'h0000);
        run_instr(16'hA001, 0, 2, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'h0000);
        run_instr(16'hB002, 1, 1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFF8, 1'b0, 16'h000A, 1'b0, 16'h0000);
        run_instr(16'hA003, 0, 0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'h0000);
        run_instr(16'hB004, 0, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFF8, 1'b0, 16'h0012, 1'b0, 16'h0000);
        run_instr(16'hC005, 3, 0, 1'b1, 16'h4C20, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h4C20, 1'b0, 16'h0000);
        run_instr(16'hA006, 0, 0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFFE, 1'b0, 16'h0000);
        run_instr(16'h0007, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
`ifdef PCSEQ_ALIGN_TRAP_EN
        run_instr(16'hA008, 0, 0, 1'b1, 16'h0103, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0103);
`else
        run_instr(16'hA008, 0, 0, 1'b1, 16'h0103, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0102, 1'b0, 16'h0000);
`endif
        run_instr(16'hF009, 0, 1, 1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0200, 1'b0, 16'h0000);

        // Halted: every stimulus that would advance the sequencer must be ignored.
        for (int i = 0; i < 20; i++) begin
            imem_ack      = 1'(i % 2);
            imem_rdata    = 16'h7777;
            instr_ready   = 1'b1;
            resolve_valid = 1'b1;
            flag_jump     = 1'b1;
            jumpAddr      = 16'h1110;
            tick();
            check_eq("halt_req", 16'(imem_req), 16'd0);
            check_eq("halt_flag", 16'(halted), 16'd1);
            check_eq("halt_pc", pc, 16'h0200);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        clear_ctrl();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("unhalt_pc", pc, 16'h0000);
        check_eq("unhalt_flag", 16'(halted), 16'd0);
        check_eq("unhalt_instr", instr, 16'h0000);
        cur_pc = 16'h0000;
        run_instr(16'h5555, 1, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b0, 16'h0000);

        // Reset coincident with an ack: the fetched word must be discarded.
        wait_req();
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        reset      = 1'b1;
        tick();
        reset    = 1'b0;
        imem_ack = 1'b0;
        check_eq("rstack_instr", instr, 16'h0000);
        check_eq("rstack_instr_pc", instr_pc, 16'h0000);
        check_eq("rstack_valid", 16'(instr_valid), 16'd0);
        check_eq("rstack_pc", pc, 16'h0000);
        tick();
        check_eq("rstack_req", 16'(imem_req), 16'd1);
        check_eq("rstack_addr", imem_addr, 16'h0000);
        check_eq("sb_drained", 16'(exp_q.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/execute sequencer for the 16-bit core. It owns the architectural PC register and runs the instruction-memory fetch handshake. It hands each fetched instruction to decode, then waits for execute to resolve the instruction and selects the next PC: sequential, taken branch, or jump. It sits between instruction memory and the decode/execute stages and replaces free-running per-clock PC update with an explicit, stallable sequence.

## Interface
- `RESET_PC`, 16'h0000, PC loaded on reset
- `TRAP_VEC`, 16'h0004, target on misaligned next PC (only with `PCSEQ_ALIGN_TRAP_EN`)

Ports:
- `clock`  in  1  sole clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `imem_req`  out  1  fetch request
- `imem_addr`  out  16  fetch address (= `pc`)
- `imem_ack`  in  1  fetch data valid this cycle
- `imem_rdata`  in  16  fetched instruction
- `instr_valid`  out  1  instruction available to decode
- `instr`  out  16  held instruction word
- `instr_pc`  out  16  address of `instr`
- `instr_ready`  in  1  decode accepts `instr`
- `resolve_valid`  in  1  execute finished current instruction
- `flag_branch`  in  1  instruction is a conditional branch
- `aluZero`  in  1  ALU zero result
- `branchOff`  in  16  sign-extended, pre-shifted branch offset
- `flag_jump`  in  1  instruction is a jump
- `jumpAddr`  in  16  fully formed jump target
- `halt`  in  1  instruction is a halt
- `pc`  out  16  architectural PC
- `halted`  out  1  sequencer stopped
- `trap`  out  1  one-cycle misalignment pulse (macro only)
- `trap_pc`  out  16  offending target (macro only)

## Operation
- States: FETCH, ISSUE, EXEC, HALTED.
- **FETCH:**
  - `imem_req`=1 and `imem_addr`=`pc`, both held until `imem_ack`.
  - On ack: latch `imem_rdata`→`instr` and `pc`→`instr_pc`, then go to ISSUE.
- **ISSUE:**
  - `instr_valid`=1.
  - On `instr_ready`: go to EXEC. `instr` and `instr_pc` stay stable until the next fetch ack.
- **EXEC:**
  - Wait for `resolve_valid`. Control inputs are sampled only in the cycle `resolve_valid`=1.
  - Next PC is computed from `seq` = `pc`+2:
    - `flag_jump`=1 → `jumpAddr`
    - else `flag_branch`&`aluZero` → `seq`+`branchOff`
    - else → `seq`
  - All sums are 16-bit modulo; carry is dropped, so 16'hFFFE+2 = 16'h0000.
  - Jump beats branch when both are set.
  - `pc` updates to the next PC. The state goes to HALTED if `halt`=1, otherwise to FETCH.
  - When `halt` and `flag_jump` are both set, `pc` still takes `jumpAddr`.
- **HALTED:**
  - `halted`=1, no requests are issued.
  - Only `reset` exits this state.
- `imem_ack` outside FETCH is ignored. `resolve_valid` outside EXEC is ignored. `instr_ready` outside ISSUE is ignored.

## Timing
- Reset values:
  - `pc`=`RESET_PC`; state=FETCH.
  - `imem_req`=0, `instr_valid`=0, `halted`=0, `trap`=0, `instr`=0, `instr_pc`=0, `trap_pc`=0.
  - `imem_req` rises in the first cycle after `reset` is sampled low.
- Reset asserted in any state (including mid-fetch or HALTED) overrides everything at that edge. An in-flight ack is discarded.
- `imem_req`, `instr_valid` and `halted` decode from registered state only. There is no combinational path from any input.
- Minimum per-instruction latency is 3 cycles: ack in the first FETCH cycle, ready in the first ISSUE cycle, resolve in the first EXEC cycle.
- Each wait stalls for an unbounded number of cycles without loss of state.
- `pc` changes only on a resolve edge or on reset.

## Configuration
- `PCSEQ_ALIGN_TRAP_EN` defined:
  - A computed next PC with bit0=1 loads `TRAP_VEC` instead.
  - `trap` pulses high for exactly one cycle (the cycle after the resolve edge).
  - `trap_pc` captures the odd address.
  - `halt` still takes priority over the state transition, but the trap is still recorded.
- Undefined:
  - Next PC bit0 is forced to 0.
  - `trap` and `trap_pc` ports are tied to 0.

## Test plan
- Reset, then ack after 2 wait cycles with rdata=16'h1234, then ready, then resolve with all flags 0 → `imem_addr`=0000 held 3 cycles, `instr`=1234, `instr_pc`=0000, `pc`=0002, next fetch at 0002.
- `pc`=0010, resolve with `flag_branch`=1, `aluZero`=1, `branchOff`=FFF8 → `pc`=000A. Same case with `aluZero`=0 → `pc`=0012.
- Resolve with `flag_jump`=1, `jumpAddr`=4C20, `flag_branch`=1, `aluZero`=1 → `pc`=4C20 (jump priority). Sequential step at `pc`=FFFE → `pc`=0000.
- Resolve with `halt`=1 → `halted`=1 and `imem_req` stays 0 for 20 cycles despite ack pulses. Then `reset` → `pc`=`RESET_PC`, fetch resumes.
- `reset` pulsed while in FETCH with ack arriving the same cycle → `instr` stays 0, `imem_addr`=`RESET_PC` next cycle.
- With the macro, jump to 0103 → `pc`=0004, `trap` high 1 cycle, `trap_pc`=0103. Without the macro → `pc`=0102.
